// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
// master: EX stage drives Start/Flush/op/operands; slave: unit returns Result/Done/Busy.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Flush;
    logic [2:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result;
    logic             Done;
    logic             Busy;

    modport master (
        output Start, Flush, MCycleOp, Operand1, Operand2,
        input  Result, Done, Busy
    );

    modport slave (
        input  Start, Flush, MCycleOp, Operand1, Operand2,
        output Result, Done, Busy
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with flush and same-cycle Busy.
// Ports: CLK, RESETn (async, active low), bus (mcycle_unit_if.slave).
module mcycle_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input logic         CLK,
    input logic         RESETn,
    mcycle_unit_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [2:0]       op;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    logic             accept;
    logic             is_div;
    logic             sgn1;
    logic             sgn2;
    logic             neg1;
    logic             neg2;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] special_res;

    logic             last_iter;
    logic [W2-1:0]    mul_add;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_res;

    // Request decode: signedness, magnitudes and one-cycle special cases
    always_comb begin
        accept = bus.Start & ~bus.Flush
               & ((state == S_IDLE) | (state == S_DONE));
        is_div = bus.MCycleOp[2];
        sgn1   = is_div ? ~bus.MCycleOp[0] : (bus.MCycleOp[1:0] != 2'b11);
        sgn2   = is_div ? ~bus.MCycleOp[0] : ~bus.MCycleOp[1];
        neg1   = sgn1 & bus.Operand1[WIDTH-1];
        neg2   = sgn2 & bus.Operand2[WIDTH-1];
        mag1   = neg1 ? -bus.Operand1 : bus.Operand1;
        mag2   = neg2 ? -bus.Operand2 : bus.Operand2;
        div_zero = is_div & (bus.Operand2 == '0);
        div_ovf  = is_div & ~bus.MCycleOp[0]
                 & (bus.Operand1 == MOST_NEG) & (bus.Operand2 == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = bus.MCycleOp[1] ? bus.Operand1 : '1;
        else
            special_res = bus.MCycleOp[1] ? '0 : bus.Operand1;
    end

    // Iteration datapath and sign fix-up
    always_comb begin
        last_iter = (state == S_MUL) ? (cnt == MUL_LAST)
                                     : (cnt == DIV_LAST);
        mul_add   = mcand * {{(W2-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
        // partial remainder shifted left with the next dividend bit
        trial     = acc[W2-1:WIDTH-1];
        diff      = trial - {1'b0, mplier};
        prod_fix  = neg_q ? -acc : acc;
        quo       = acc[WIDTH-1:0];
        rem       = acc[W2-1:WIDTH];
        if (op[2]) begin
            if (op[1])
                fix_res = neg_r ? -rem : rem;
            else
                fix_res = neg_q ? -quo : quo;
        end else begin
            if (op[1:0] == 2'b00)
                fix_res = prod_fix[WIDTH-1:0];
            else
                fix_res = prod_fix[W2-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.Flush) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (!accept)
                        state_nx = S_IDLE;
                    else if (special)
                        state_nx = S_DONE;
                    else if (is_div)
                        state_nx = S_DIV;
                    else
                        state_nx = S_MUL;
                end
                S_MUL, S_DIV: begin
                    if (last_iter)
                        state_nx = S_FIX;
                end
                S_FIX:   state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            op       <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_nx == S_DONE);
            if (accept) begin
                op     <= bus.MCycleOp;
                neg_q  <= neg1 ^ neg2;
                neg_r  <= neg1;
                cnt    <= '0;
                mplier <= mag2;
                mcand  <= {{WIDTH{1'b0}}, mag1};
                acc    <= is_div ? {{WIDTH{1'b0}}, mag1} : '0;
                if (special)
                    result_q <= special_res;
            end else begin
                unique case (state)
                    S_MUL: begin
                        acc    <= acc + mul_add;
                        mcand  <= mcand << MUL_BITS;
                        mplier <= mplier >> MUL_BITS;
                        cnt    <= cnt + 1'b1;
                    end
                    S_DIV: begin
                        if (!diff[WIDTH])
                            acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                    S_FIX: begin
                        if (!bus.Flush)
                            result_q <= fix_res;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Busy   = RESETn & (accept | (state == S_MUL)
                      | (state == S_DIV) | (state == S_FIX));
    assign bus.Result = result_q;
    assign bus.Done   = done_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// Randomized + directed bench for mcycle_unit against an arithmetic model.
// Three instances cover MUL_BITS = 1, 2 and 4 at WIDTH = 32.
module tb_mcycle_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    int          sel;
    logic        done_s;
    logic        busy_s;
    logic [31:0] res_s;
    logic [31:0] last_res;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mcycle_unit_if #(.WIDTH(32)) bus1 ();
    mcycle_unit_if #(.WIDTH(32)) bus2 ();
    mcycle_unit_if #(.WIDTH(32)) bus4 ();

    assign bus1.Start = st[0];
    assign bus2.Start = st[1];
    assign bus4.Start = st[2];
    assign bus1.Flush = flush;
    assign bus2.Flush = flush;
    assign bus4.Flush = flush;
    assign bus1.MCycleOp = op;
    assign bus2.MCycleOp = op;
    assign bus4.MCycleOp = op;
    assign bus1.Operand1 = opa;
    assign bus2.Operand1 = opa;
    assign bus4.Operand1 = opa;
    assign bus1.Operand2 = opb;
    assign bus2.Operand2 = opb;
    assign bus4.Operand2 = opb;

    mcycle_unit #(.WIDTH(32), .MUL_BITS(1)) dut1 (
        .CLK(clk), .RESETn(rst_n), .bus(bus1.slave));
    mcycle_unit #(.WIDTH(32), .MUL_BITS(2)) dut2 (
        .CLK(clk), .RESETn(rst_n), .bus(bus2.slave));
    mcycle_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .CLK(clk), .RESETn(rst_n), .bus(bus4.slave));

    always_comb begin
        done_s = bus2.Done;
        busy_s = bus2.Busy;
        res_s  = bus2.Result;
        case (sel)
            0: begin
                done_s = bus1.Done;
                busy_s = bus1.Busy;
                res_s  = bus1.Result;
            end
            2: begin
                done_s = bus4.Done;
                busy_s = bus4.Busy;
                res_s  = bus4.Result;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     pv;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        pv  = '0;
        case (o)
            3'd0: begin pv = sx * sy; return pv[31:0]; end
            3'd1: begin pv = sx * sy; return pv[63:32]; end
            3'd2: begin pv = sx * longint'(uy); return pv[63:32]; end
            3'd3: begin pv = ux * uy; return pv[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                pv = sx / sy;
                return pv[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                pv = sx % sy;
                return pv[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input int mb);
        if (o[2]) begin
            if (y == 0) return 1;
            if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        return 32 / mb + 2;
    endfunction

    task automatic run_op(input int s, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input bit b2b, output int lat,
                          output logic [31:0] res, output bit busy_ok);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        sel = s;
        op = o;
        opa = x;
        opb = y;
        st[s] = 1'b1;
        lat = -1;
        res = '0;
        busy_ok = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                st[s] = 1'b0;
                if (c == 1) begin
                    opa = $urandom;
                    opb = $urandom;
                    op  = 3'($urandom_range(0, 7));
                end
            end
            #3;
            if (c > 0 && done_s) begin
                lat = c;
                res = res_s;
                if (busy_s) busy_ok = 1'b0;
                break;
            end
            if (!busy_s) busy_ok = 1'b0;
        end
        st[s] = 1'b0;
    endtask

    task automatic do_op(input string tag, input int s, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input bit b2b);
        int          lat;
        logic [31:0] res;
        bit          bok;
        int          mb;
        mb = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        run_op(s, o, x, y, b2b, lat, res, bok);
        check({tag, "_res"}, res, ref_model(o, x, y));
        check({tag, "_lat"}, lat, exp_lat(o, x, y, mb));
        check({tag, "_busy"}, bok, 1);
        last_res = res;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #4;
            if (done_s) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  o;
        st = '0;
        flush = 1'b0;
        op = '0;
        opa = '0;
        opb = '0;
        sel = 1;
        last_res = '0;

        #12;
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        check("rst_result", res_s, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op("mul_ff", 1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_ff_lit", last_res, 32'h0000_0001);
        do_op("mulh_ff", 1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulh_ff_lit", last_res, 32'h0000_0000);
        do_op("mulhu_ff", 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhu_ff_lit", last_res, 32'hFFFF_FFFE);
        for (int s = 0; s < 3; s++) begin
            do_op("mulhsu_ff", s, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
            check("mulhsu_ff_lit", last_res, 32'hFFFF_FFFF);
        end

        do_op("div_m7", 1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_lit", last_res, 32'hFFFF_FFFD);
        do_op("rem_m7", 1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        check("rem_m7_lit", last_res, 32'hFFFF_FFFF);
        do_op("divu_big", 1, 3'd5, 32'hFFFF_FFF9, 32'd2, 0);
        check("divu_big_lit", last_res, 32'h7FFF_FFFC);

        do_op("divu_z", 1, 3'd5, 32'd5, 32'd0, 0);
        check("divu_z_lit", last_res, 32'hFFFF_FFFF);
        do_op("rem_z", 1, 3'd6, 32'd5, 32'd0, 0);
        check("rem_z_lit", last_res, 32'd5);
        do_op("div_ovf", 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_lit", last_res, 32'h8000_0000);
        do_op("rem_ovf", 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("rem_ovf_lit", last_res, 32'h0);

        // flush in cycle 5 of a divide
        sel = 1;
        @(posedge clk);
        #1;
        prev = res_s;
        op = 3'd5;
        opa = 32'd1000;
        opb = 32'd7;
        st[1] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            st[1] = 1'b0;
            if (c == 5) flush = 1'b1;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        #3;
        check("flush_idle", busy_s, 0);
        watch_no_done("flush_nodone", 40);
        check("flush_result", res_s, prev);

        // Flush and Start together
        @(posedge clk);
        #1;
        st[1] = 1'b1;
        flush = 1'b1;
        #3;
        check("fs_busy", busy_s, 0);
        @(posedge clk);
        #1;
        st[1] = 1'b0;
        flush = 1'b0;
        #3;
        check("fs_not_accepted", busy_s, 0);
        watch_no_done("fs_nodone", 40);

        // back-to-back: second Start issued in the first Done cycle
        do_op("b2b_a", 1, 3'd0, 32'd3, 32'd5, 0);
        check("b2b_a_lit", last_res, 32'd15);
        do_op("b2b_b", 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check("b2b_b_lit", last_res, 32'hFFFF_FFFE);
        @(posedge clk);
        #4;
        check("done_pulse", done_s, 0);

        // reset in cycle 10 of a multiply
        @(posedge clk);
        #1;
        sel = 1;
        op = 3'd0;
        opa = 32'd7;
        opb = 32'd9;
        st[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            st[1] = 1'b0;
        end
        check("pre_rst_busy", busy_s, 1);
        rst_n = 1'b0;
        st[1] = 1'b1;
        #1;
        check("mid_rst_busy", busy_s, 0);
        check("mid_rst_done", done_s, 0);
        check("mid_rst_result", res_s, 0);
        st[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch_no_done("post_rst_nodone", 40);
        check("post_rst_result", res_s, 0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick_operand();
            y = pick_operand();
            do_op("rnd2", 1, o, x, y, 0);
        end
        for (int i = 0; i < 6; i++) begin
            o = 3'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            do_op("rnd1", 0, o, x, y, 0);
            do_op("rnd4", 2, o, x, y, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Parametrised multi-cycle multiply/divide unit for the EX stage: the next generation of the core's iterative mul/div block. It implements all eight RV32M/RV64M operations with a single selected result, retires a configurable number of multiplier bits per cycle, and resolves divide-by-zero and signed overflow in one cycle. It adds a pipeline flush/abort input. It raises `Busy` in the same cycle `Start` is asserted, so the hazard unit can stall without an extra register stage.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; even, 8 to 64.
- `MUL_BITS`, 2, multiplier bits retired per multiply iteration; one of 1, 2, 4; must divide `WIDTH`.

Ports:
- `CLK`, input, 1, rising-edge clock.
- `RESETn`, input, 1, asynchronous active-low reset.
- `Start`, input, 1, request; accepted when the unit is idle or in DONE.
- `Flush`, input, 1, synchronous abort of any in-flight or requested operation.
- `MCycleOp`, input, 3, operation using RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `Operand1`, input, `WIDTH`, rs1: multiplicand or dividend.
- `Operand2`, input, `WIDTH`, rs2: multiplier or divisor.
- `Result`, output, `WIDTH`, selected result; registered; held until the next Done.
- `Done`, output, 1, one-cycle pulse; `Result` is valid while it is high.
- `Busy`, output, 1, stall request; combinational.

## Operation

- States: IDLE, MUL, DIV, FIX, DONE. The state register, counter, operand latches, `Result` and `Done` are all cleared asynchronously by `RESETn`=0.
- Accept condition: `Start`=1, `Flush`=0, state is IDLE or DONE. On accept:
  - latch `MCycleOp`, the operand magnitudes and the sign flags.
  - Operands may change afterwards without affecting the operation.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: `Operand1` signed, `Operand2` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV/REM: both signed.
- Multiply datapath:
  - Unsigned shift-add on magnitudes, 2·`WIDTH`-bit product accumulator.
  - Each MUL cycle adds (multiplicand × the low `MUL_BITS` bits of the multiplier) at the current shift position, then shifts the multiplier right by `MUL_BITS`.
  - Runs `WIDTH/MUL_BITS` iterations.
  - FIX: two's-complement negate the full 2·`WIDTH` product when the effective signs differ.
  - Result: MUL takes the low word; MULH, MULHSU and MULHU take the high word.
- Divide datapath:
  - Restoring division on magnitudes, one quotient bit per cycle, `WIDTH` iterations.
  - FIX: negate the quotient if the signed operation has differing signs. Negate the remainder if the signed dividend is negative, so the remainder takes the dividend's sign.
- Special cases, decided at accept. They go IDLE→DONE directly and skip MUL/DIV/FIX:
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give `Operand1`.
  - Signed overflow (`Operand1` = most-negative, `Operand2` = all ones, op DIV/REM): DIV gives `Operand1`; REM gives 0.
- `Flush`=1:
  - From any state, the next state is IDLE and no `Done` is produced.
  - `Result` keeps its previous value.
  - `Flush` and `Start` together: `Flush` wins; the request is not accepted.
- Transitions:
  - IDLE/DONE → MUL, DIV or DONE on accept; otherwise → IDLE.
  - MUL/DIV → FIX after the last iteration.
  - FIX → DONE.

## Timing

- Call the accept cycle cycle 0.
- `Busy` = (`Start` & ~`Flush` & state∈{IDLE, DONE}) | state∈{MUL, DIV, FIX}. It is 0 in DONE unless a new request arrives, and 0 while `RESETn`=0.
- Multiply:
  - MUL state in cycles 1..N, where N = `WIDTH/MUL_BITS`.
  - FIX in cycle N+1.
  - `Done`=1 and `Busy`=0 in cycle N+2.
  - Default parameters: `Done` in cycle 18.
- Divide: DIV in cycles 1..`WIDTH`, FIX in cycle `WIDTH`+1, `Done` in cycle `WIDTH`+2 (34 with the default).
- Special cases: `Done` in cycle 1.
- Back-to-back: a `Start` in the DONE cycle is accepted, so the next operation's cycle 0 is the previous operation's `Done` cycle.
- Reset mid-operation: all outputs are 0 immediately. The first `Start` after reset release follows the normal rules.
- `Start` while in MUL, DIV or FIX is ignored. It is not queued.

## Test plan

- MUL, MULH and MULHU with 0xFFFFFFFF × 0xFFFFFFFF (`WIDTH`=32, `MUL_BITS`=2):
  - Results are 0x00000001, 0x00000000 and 0xFFFFFFFE respectively.
  - `Done` in cycle 18 each; `Busy` high in cycles 0–17.
- MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. Repeat with `MUL_BITS`=1 and 4 → same value, with `Done` in cycles 34 and 10.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, both with `Done` in cycle 34. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special cases, each with `Done` in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Flush during a divide:
  - `Flush` in cycle 5 → state IDLE at cycle 6, no `Done`, `Result` unchanged.
  - `Flush` and `Start` together in the same cycle → request not accepted.
- Back-to-back and reset:
  - `Start` in the DONE cycle → a second result follows the normal latency.
  - `RESETn` low in cycle 10 of a multiply → `Busy`, `Done` and `Result` go to 0 at once. No `Done` after release.
